// File: rtl/trace_width_ctl.sv
// Trace port width controller: hunts 4->2->1 for sync, locks, or pins a forced width.
// Optional macro TRACE_WIDTH_CTL_STATS_EN adds the saturating huntCount sweep counter.
module trace_width_ctl #(
  parameter int DWELL = 1024,
  parameter int LOSS  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] forceWidth,
  input  logic       syncIn,
  output logic [2:0] width,
  output logic       locked,
  output logic       scanning,
  output logic       widthChg,
  output logic [7:0] huntCount,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2,
    S_FIXED  = 2'd3
  } state_t;

  localparam logic [15:0] DWELL_RLD = 16'(DWELL - 1);
  localparam logic [15:0] LOSS_MAX  = 16'(LOSS - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_width, w_width_nxt;
  logic        r_locked, w_locked_nxt;
  logic        r_scanning, w_scanning_nxt;
  logic        r_widthchg, w_widthchg_nxt;
  logic [15:0] r_dwell, w_dwell_nxt;
  logic [15:0] r_loss, w_loss_nxt;
  logic [2:0]  w_eff;
  logic        w_forced;
  logic        w_dwell_zero;
  logic        w_loss_max;

  // Only 1, 2 and 4 are real widths; every other code means auto-hunt.
  always_comb begin
    case (forceWidth)
      3'd1, 3'd2, 3'd4: w_eff = forceWidth;
      default:          w_eff = 3'd0;
    endcase
  end

  assign w_forced     = (w_eff != 3'd0);
  assign w_dwell_zero = (r_dwell == 16'd0);
  assign w_loss_max   = (r_loss == LOSS_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_width    <= 3'd4;
      r_locked   <= 1'b0;
      r_scanning <= 1'b0;
      r_widthchg <= 1'b0;
      r_dwell    <= 16'd0;
      r_loss     <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_width    <= w_width_nxt;
      r_locked   <= w_locked_nxt;
      r_scanning <= w_scanning_nxt;
      r_widthchg <= w_widthchg_nxt;
      r_dwell    <= w_dwell_nxt;
      r_loss     <= w_loss_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = w_forced ? S_FIXED : S_HUNT;
        S_HUNT:   w_state_nxt = w_forced ? S_FIXED : (syncIn ? S_LOCKED : S_HUNT);
        S_LOCKED: w_state_nxt = w_forced ? S_FIXED :
                                ((!syncIn && w_loss_max) ? S_HUNT : S_LOCKED);
        S_FIXED:  w_state_nxt = w_forced ? S_FIXED : S_HUNT;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Sync beats dwell expiry in HUNT, so the syncIn branch is tested first.
  always_comb begin
    w_width_nxt    = r_width;
    w_locked_nxt   = r_locked;
    w_dwell_nxt    = r_dwell;
    w_loss_nxt     = r_loss;
    w_scanning_nxt = (w_state_nxt == S_HUNT);
    if (!enable) begin
      w_locked_nxt = 1'b0;
    end else if (w_forced) begin
      w_width_nxt  = w_eff;
      w_locked_nxt = syncIn;
    end else begin
      case (r_state)
        S_IDLE, S_FIXED: begin
          w_width_nxt  = 3'd4;
          w_locked_nxt = 1'b0;
          w_dwell_nxt  = DWELL_RLD;
        end
        S_HUNT: begin
          if (syncIn) begin
            w_locked_nxt = 1'b1;
            w_loss_nxt   = 16'd0;
          end else if (w_dwell_zero) begin
            w_dwell_nxt = DWELL_RLD;
            case (r_width)
              3'd4:    w_width_nxt = 3'd2;
              3'd2:    w_width_nxt = 3'd1;
              default: w_width_nxt = 3'd4;
            endcase
          end else begin
            w_dwell_nxt = r_dwell - 16'd1;
          end
        end
        S_LOCKED: begin
          if (syncIn) begin
            w_loss_nxt = 16'd0;
          end else if (w_loss_max) begin
            w_locked_nxt = 1'b0;
            w_loss_nxt   = 16'd0;
            w_dwell_nxt  = DWELL_RLD;
          end else begin
            w_loss_nxt = r_loss + 16'd1;
          end
        end
        default: w_locked_nxt = 1'b0;
      endcase
    end
    w_widthchg_nxt = (w_width_nxt != r_width);
  end

`ifdef TRACE_WIDTH_CTL_STATS_EN
  logic [7:0] r_hunt_cnt;
  logic       w_wrap;

  // A sweep completes when hunting wraps from width 1 back to 4.
  assign w_wrap = enable && (r_state == S_HUNT) && !w_forced && !syncIn &&
                  w_dwell_zero && (r_width == 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hunt_cnt <= 8'd0;
    end else if (w_wrap && (r_hunt_cnt != 8'hFF)) begin
      r_hunt_cnt <= r_hunt_cnt + 8'd1;
    end
  end

  assign huntCount = r_hunt_cnt;
`else
  assign huntCount = 8'd0;
`endif

  assign width       = r_width;
  assign locked      = r_locked;
  assign scanning    = r_scanning;
  assign widthChg    = r_widthchg;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_trace_width_ctl.sv
// Bench for trace_width_ctl with DWELL=8, LOSS=4: vector table plus hand-written hunt/lock/reset sequences.
module tb_trace_width_ctl;
  localparam int DWELL = 8;
  localparam int LOSS  = 4;
`ifdef TRACE_WIDTH_CTL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  localparam logic [1:0] ST_I = 2'd0, ST_H = 2'd1, ST_L = 2'd2, ST_F = 2'd3;

  logic       clk = 1'b0;
  logic       rst, enable, sync_in;
  logic [2:0] force_w;
  logic [2:0] width;
  logic       locked, scanning, width_chg;
  logic [7:0] hunt_count;
  logic [1:0] dbg_state;

  trace_width_ctl #(.DWELL(DWELL), .LOSS(LOSS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .forceWidth(force_w), .syncIn(sync_in),
    .width(width), .locked(locked), .scanning(scanning), .widthChg(width_chg),
    .huntCount(hunt_count), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       en;
    logic [2:0] fw;
    logic       sy;
    int         n;
    logic [2:0] w;
    logic       lk;
    logic       sc;
    logic       chg;
    logic [1:0] st;
  } vec_t;
  vec_t vt[16];

  function automatic vec_t mk(logic en, logic [2:0] fw, logic sy, int n,
                              logic [2:0] w, logic lk, logic sc, logic chg, logic [1:0] st);
    vec_t v;
    v.en = en; v.fw = fw; v.sy = sy; v.n = n;
    v.w = w; v.lk = lk; v.sc = sc; v.chg = chg; v.st = st;
    return v;
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; force_w = 3'd0; sync_in = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  // scoreboard
  task automatic expect_obs(input logic [2:0] w, input logic lk, input logic sc,
                            input logic chg, input logic [1:0] st);
    exp_q.push_back({w, lk, sc, chg, st});
  endtask

  task automatic check_obs(input string name);
    logic [7:0] e, a;
    checks++;
    a = {width, locked, scanning, width_chg, dbg_state};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got w=%0d lk=%b sc=%b chg=%b st=%0d, want w=%0d lk=%b sc=%b chg=%b st=%0d",
                 name, a[7:5], a[4], a[3], a[2], a[1:0], e[7:5], e[4], e[3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] hunt_w(input int c);
    case (((c - 1) / DWELL) % 3)
      0:       return 3'd4;
      1:       return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  initial begin
    int pulses;
    logic [2:0] prev, ew;

    // reset state and enable gating after release
    rst = 1'b1; enable = 1'b0; force_w = 3'd0; sync_in = 1'b0;
    step(2);
    expect_obs(3'd4, 0, 0, 0, ST_I); check_obs("reset");
    check_val("reset_huntcount", hunt_count, 0);
    rst = 1'b0;
    step(3);
    expect_obs(3'd4, 0, 0, 0, ST_I); check_obs("idle_while_disabled");
    enable = 1'b1;
    step(1);
    expect_obs(3'd4, 0, 1, 0, ST_H); check_obs("first_enable");

    // full hunt sweep, then lock on dwell-expiry cycle at width 2
    do_reset();
    enable = 1'b1;
    prev = 3'd4; pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      ew = hunt_w(c);
      expect_obs(ew, 0, 1, ew != prev, ST_H);
      check_obs($sformatf("hunt_c%0d", c));
      if (c <= 25 && width_chg) pulses++;
      if (c == 25) check_val("sweep1_huntcount", hunt_count, STATS);
      prev = ew;
    end
    check_val("sweep1_chg_pulses", pulses, 3);
    sync_in = 1'b1;
    step(1);
    expect_obs(3'd2, 1, 0, 0, ST_L); check_obs("sync_wins_expiry");

    // loss counter: 3 low cycles tolerated, 4 drop the lock
    sync_in = 1'b0; step(3);
    expect_obs(3'd2, 1, 0, 0, ST_L); check_obs("loss3_holds");
    sync_in = 1'b1; step(1);
    expect_obs(3'd2, 1, 0, 0, ST_L); check_obs("loss_recover");
    sync_in = 1'b0; step(3);
    expect_obs(3'd2, 1, 0, 0, ST_L); check_obs("loss3b_holds");
    step(1);
    expect_obs(3'd2, 0, 1, 0, ST_H); check_obs("loss4_unlock");

    // vector table: forcing, illegal codes, enable drop
    vt[0]  = mk(1, 3'd0, 0, 1, 3'd4, 0, 1, 0, ST_H);
    vt[1]  = mk(1, 3'd2, 0, 1, 3'd2, 0, 0, 1, ST_F);
    vt[2]  = mk(1, 3'd4, 1, 1, 3'd4, 1, 0, 1, ST_F);
    vt[3]  = mk(1, 3'd4, 0, 1, 3'd4, 0, 0, 0, ST_F);
    vt[4]  = mk(1, 3'd1, 0, 1, 3'd1, 0, 0, 1, ST_F);
    vt[5]  = mk(1, 3'd5, 0, 1, 3'd4, 0, 1, 1, ST_H);
    vt[6]  = mk(1, 3'd0, 1, 1, 3'd4, 1, 0, 0, ST_L);
    vt[7]  = mk(0, 3'd0, 1, 1, 3'd4, 0, 0, 0, ST_I);
    vt[8]  = mk(1, 3'd7, 0, 1, 3'd4, 0, 1, 0, ST_H);
    vt[9]  = mk(1, 3'd0, 0, 8, 3'd2, 0, 1, 1, ST_H);
    vt[10] = mk(1, 3'd0, 1, 1, 3'd2, 1, 0, 0, ST_L);
    vt[11] = mk(0, 3'd0, 1, 1, 3'd2, 0, 0, 0, ST_I);
    vt[12] = mk(1, 3'd1, 0, 1, 3'd1, 0, 0, 1, ST_F);
    vt[13] = mk(1, 3'd1, 1, 1, 3'd1, 1, 0, 0, ST_F);
    vt[14] = mk(1, 3'd6, 1, 1, 3'd4, 0, 1, 1, ST_H);
    vt[15] = mk(1, 3'd3, 0, 1, 3'd4, 0, 1, 0, ST_H);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      enable = vt[i].en; force_w = vt[i].fw; sync_in = vt[i].sy;
      expect_obs(vt[i].w, vt[i].lk, vt[i].sc, vt[i].chg, vt[i].st);
      step(vt[i].n);
      check_obs($sformatf("vec%0d", i));
    end

    // asynchronous reset between clock edges
    do_reset();
    enable = 1'b1;
    step(10);
    expect_obs(3'd2, 0, 1, 0, ST_H); check_obs("pre_async_reset");
    #3;
    rst = 1'b1;
    #1;
    expect_obs(3'd4, 0, 0, 0, ST_I); check_obs("async_reset");
    step(1);
    rst = 1'b0;

    // huntCount saturation over 300 sweeps
    do_reset();
    enable = 1'b1;
    step(1 + 2 * 3 * DWELL);
    check_val("huntcount_2", hunt_count, STATS * 2);
    step(298 * 3 * DWELL);
    check_val("huntcount_sat", hunt_count, STATS * 255);
    enable = 1'b0;
    step(2);
    check_val("huntcount_keep_on_disable", hunt_count, STATS * 255);

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
